// File: rtl/bin2bcd_conv.sv
// Sequential 10-bit binary to 3-digit BCD converter (shift-and-add-3),
// registered digit outputs held stable between conversions for a display mux.
module bin2bcd_conv #(
  parameter bit BLANK_ON_OVF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] bin,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic [3:0] dout0,
  output logic [3:0] dout1,
  output logic [3:0] dout2
);

  localparam int unsigned BIN_W  = 10;
  localparam int unsigned ACC_W  = 14;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned NDIG   = 3;
  localparam int unsigned MAX_OK = 999;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [BIN_W-1:0]     sr_q, sr_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovfp_q, ovfp_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic [DIG_W-1:0]     d0_q, d0_d;
  logic [DIG_W-1:0]     d1_q, d1_d;
  logic [DIG_W-1:0]     d2_q, d2_d;

  logic [ACC_W-1:0]       acc_adj;
  logic [ACC_W+BIN_W-1:0] shifted;
  logic [ACC_W-1:0]       acc_shift;
  logic [BIN_W-1:0]       sr_shift;

  // Add-3 correction on the three low digits; the 2-bit thousands field never reaches 5.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (acc_q[i*DIG_W +: DIG_W] >= DIG_W'(5)) begin
        acc_adj[i*DIG_W +: DIG_W] = acc_q[i*DIG_W +: DIG_W] + DIG_W'(3);
      end
    end
    shifted   = {acc_adj, sr_q} << 1;
    acc_shift = shifted[ACC_W+BIN_W-1:BIN_W];
    sr_shift  = shifted[BIN_W-1:0];
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovfp_d  = ovfp_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bin;
          acc_d   = '0;
          cnt_d   = '0;
          ovfp_d  = (bin > BIN_W'(MAX_OK));
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_shift;
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ovf_d   = ovfp_q;
          if (ovfp_q && BLANK_ON_OVF) begin
            d0_d = 4'hF;
            d1_d = 4'hF;
            d2_d = 4'hF;
          end else begin
            d0_d = acc_shift[0*DIG_W +: DIG_W];
            d1_d = acc_shift[1*DIG_W +: DIG_W];
            d2_d = acc_shift[2*DIG_W +: DIG_W];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovfp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovfp_q  <= ovfp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign dout0 = d0_q;
  assign dout1 = d1_q;
  assign dout2 = d2_q;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Bench for bin2bcd_conv: blanking and non-blanking instances share stimulus and
// are checked every cycle against a decimal-arithmetic model plus directed literals.
module tb_bin2bcd_conv;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] bin;

  logic       a_busy, a_done, a_ovf;
  logic [3:0] a_d0, a_d1, a_d2;
  logic       b_busy, b_done, b_ovf;
  logic [3:0] b_d0, b_d1, b_d2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bin2bcd_conv dut_a (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(a_busy), .done(a_done), .ovf(a_ovf),
    .dout0(a_d0), .dout1(a_d1), .dout2(a_d2)
  );

  bin2bcd_conv #(.BLANK_ON_OVF(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(b_busy), .done(b_done), .ovf(b_ovf),
    .dout0(b_d0), .dout1(b_d1), .dout2(b_d2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] dec3(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Model: a conversion takes 10 edges after acceptance; results are decimal digits.
  bit         m_valid = 0;
  bit         m_busy  = 0;
  bit         m_done  = 0;
  bit         m_ovf   = 0;
  int         m_cnt   = 0;
  int         m_val   = 0;
  logic [11:0] m_da   = '0;
  logic [11:0] m_db   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_busy = 0; m_done = 0; m_cnt = 0;
      m_ovf = 0; m_da = '0; m_db = '0;
    end else if (!m_busy) begin
      m_done = 0;
      if (start) begin
        m_busy = 1; m_cnt = 0; m_val = int'(bin);
      end
    end else begin
      m_cnt++;
      if (m_cnt == 10) begin
        m_busy = 0;
        m_done = 1;
        m_ovf  = (m_val > 999);
        m_db   = dec3(m_val);
        m_da   = m_ovf ? 12'hFFF : dec3(m_val);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("a_busy", 32'(a_busy), 32'(m_busy));
      chk("a_done", 32'(a_done), 32'(m_done));
      chk("a_ovf",  32'(a_ovf),  32'(m_ovf));
      chk("a_digits", 32'({a_d2, a_d1, a_d0}), 32'(m_da));
      chk("b_busy", 32'(b_busy), 32'(m_busy));
      chk("b_done", 32'(b_done), 32'(m_done));
      chk("b_ovf",  32'(b_ovf),  32'(m_ovf));
      chk("b_digits", 32'({b_d2, b_d1, b_d0}), 32'(m_db));
    end
  end

  // Waits from the first negedge after acceptance until done is seen.
  task automatic wait_done(output int k, output int busyn);
    k = 0;
    busyn = 0;
    while (!a_done && k < 30) begin
      if (a_busy) busyn++;
      @(negedge clk);
      k++;
    end
    if (k >= 30) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles", k);
    end
  endtask

  task automatic conv(input int v, input logic [11:0] ea, input logic [11:0] eb, input bit eovf);
    int k, bn;
    @(negedge clk);
    start = 1'b1;
    bin   = 10'(v);
    @(negedge clk);
    start = 1'b0;
    wait_done(k, bn);
    chk($sformatf("latency_%0d", v), 32'(k), 32'd10);
    chk($sformatf("busy_len_%0d", v), 32'(bn), 32'd10);
    chk($sformatf("lit_a_%0d", v), 32'({a_d2, a_d1, a_d0}), 32'(ea));
    chk($sformatf("lit_b_%0d", v), 32'({b_d2, b_d1, b_d0}), 32'(eb));
    chk($sformatf("lit_ovf_%0d", v), 32'(a_ovf), 32'(eovf));
  endtask

  task automatic no_done_for(input string name, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (a_done || b_done) seen++;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k, bn, t1, t2;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_ovf", 32'(a_ovf), 32'd0);
    chk("rst_digits", 32'({a_d2, a_d1, a_d0}), 32'h000);
    rst = 1'b0;
    @(negedge clk);

    conv(0,    12'h000, 12'h000, 1'b0);
    conv(255,  12'h255, 12'h255, 1'b0);
    conv(999,  12'h999, 12'h999, 1'b0);
    conv(7,    12'h007, 12'h007, 1'b0);
    conv(1000, 12'hFFF, 12'h000, 1'b1);
    conv(1023, 12'hFFF, 12'h023, 1'b1);
    conv(508,  12'h508, 12'h508, 1'b0);

    // Start and operand change while busy must be ignored.
    @(negedge clk);
    start = 1'b1;
    bin   = 10'd123;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    bin   = 10'd456;
    @(negedge clk);
    start = 1'b0;
    wait_done(k, bn);
    chk("ignored_latency", 32'(k), 32'd7);
    chk("ignored_result", 32'({a_d2, a_d1, a_d0}), 32'h123);
    no_done_for("ignored_no_second_done", 14);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1;
    bin   = 10'd42;
    @(negedge clk);
    wait_done(k, bn);
    chk("b2b_first", 32'({a_d2, a_d1, a_d0}), 32'h042);
    t1  = cyc;
    bin = 10'd87;
    @(negedge clk);
    wait_done(k, bn);
    start = 1'b0;
    chk("b2b_second", 32'({a_d2, a_d1, a_d0}), 32'h087);
    t2 = cyc;
    chk("b2b_spacing", 32'(t2 - t1), 32'd11);
    no_done_for("b2b_no_third", 13);

    // Reset mid-conversion aborts with no done.
    @(negedge clk);
    start = 1'b1;
    bin   = 10'd500;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(a_busy), 32'd0);
    chk("abort_done", 32'(a_done), 32'd0);
    chk("abort_digits", 32'({a_d2, a_d1, a_d0}), 32'h000);
    chk("abort_ovf", 32'(a_ovf), 32'd0);
    no_done_for("abort_no_done", 15);
    conv(500, 12'h500, 12'h500, 1'b0);

    // Reset wins over start in the same cycle.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    bin   = 10'd77;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_over_start_busy", 32'(a_busy), 32'd0);
    no_done_for("rst_over_start_no_done", 13);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
